// File: rtl/ed25519_verify_s_core.sv
// Verifier-side Ed25519 scalar stage: flags canonical S (S < L) and reduces the
// 512-bit digest to k = H mod L with one shift-subtract step per digest bit.
`timescale 1ns/1ps
module ed25519_verify_s_core #(
  parameter int HASH_W = 512,
  parameter int SIGN_W = 256,
  parameter int K_W    = 253
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  output logic              oReady,
  output logic              oDone,
  input  logic [SIGN_W-1:0] iSign,
  input  logic [HASH_W-1:0] iHashd_ram,
  output logic [K_W-1:0]    oK,
  output logic              oSValid
);

  localparam logic [255:0] L_FULL =
    256'h1000_0000_0000_0000_0000_0000_0000_0000_14DE_F9DE_A2F7_9CD6_5812_631A_5CF5_D3ED;
  localparam logic [K_W:0] L_T  = L_FULL[K_W:0];
  localparam int           CNT_W = $clog2(HASH_W);

  typedef enum logic [1:0] {IDLE, CHECK, REDUCE, DONE} state_t;

  state_t             state, state_next;
  logic [SIGN_W-1:0]  s_cap;
  logic [HASH_W-1:0]  h_cap;
  logic [K_W-1:0]     r;
  logic [CNT_W-1:0]   cnt;
  logic               sv;

  // r < L keeps 2r+b below 2L, so a single conditional subtract suffices.
  function automatic logic [K_W-1:0] mod_step(input logic [K_W-1:0] acc, input logic bit_in);
    logic [K_W:0] t;
    logic [K_W:0] d;
    t = {acc, bit_in};
    d = t - L_T;
    return (t >= L_T) ? d[K_W-1:0] : t[K_W-1:0];
  endfunction

  function automatic logic canonical(input logic [SIGN_W-1:0] s);
    return s < {{(SIGN_W-K_W-1){1'b0}}, L_T};
  endfunction

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iEn) state_next = CHECK;
      CHECK:   state_next = REDUCE;
      REDUCE:  if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign oReady = (state == IDLE);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s_cap   <= '0;
      h_cap   <= '0;
      r       <= '0;
      cnt     <= '0;
      sv      <= 1'b0;
      oK      <= '0;
      oSValid <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oDone <= (state == DONE);
      case (state)
        IDLE: begin
          if (iEn) begin
            s_cap <= iSign;
            h_cap <= iHashd_ram;
          end
        end
        CHECK: begin
          sv  <= canonical(s_cap);
          r   <= '0;
          cnt <= CNT_W'(HASH_W - 1);
        end
        REDUCE: begin
          r <= mod_step(r, h_cap[cnt]);
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        DONE: begin
          oK      <= r;
          oSValid <= sv;
        end
        default: ;
      endcase
    end
  end

endmodule
